// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, sequential PC step, NOP encoding
// and the IF/ID pipeline record that the ID stage also consumes.
package core_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned PC_STEP = 4;

  // All-zero word is the NOP, so a cleared pipeline slot is a legal bubble.
  localparam logic [WIDTH-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inst;
    logic             valid;
  } if_id_t;

  // Branch targets are word aligned; the low two address bits are dropped.
  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
    return addr & ~WIDTH'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch control, instruction-memory port and the
// IF/ID outputs towards decode.
//   master : the fetch stage (drives inst_adrs, if_id_*, fetch_count)
//   slave  : the surrounding core / instruction memory
interface fetch_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             freeze;
  logic             br_taken;
  logic [WIDTH-1:0] br_addr;
  logic [WIDTH-1:0] inst_adrs;
  logic [WIDTH-1:0] inst_in;
  logic [WIDTH-1:0] if_id_pc;
  logic [WIDTH-1:0] if_id_inst;
  logic             if_id_valid;
  logic [WIDTH-1:0] fetch_count;

  modport master (
    input  freeze, br_taken, br_addr, inst_in,
    output inst_adrs, if_id_pc, if_id_inst, if_id_valid, fetch_count
  );

  modport slave (
    output freeze, br_taken, br_addr, inst_in,
    input  inst_adrs, if_id_pc, if_id_inst, if_id_valid, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register with asynchronous reset to all-zero, synchronous
// clear (flush) and hold (stall). Clear has priority over hold so a redirect
// always squashes the slot even while the pipeline is frozen.
//   clk, rst : clock, asynchronous active-high reset
//   hold_i   : keep current contents
//   clear_i  : load all-zero (bubble)
//   d_i      : next contents when neither hold nor clear
//   q_o      : registered contents
module if_id_reg
  import core_pkg::*;
#(
  parameter type T = if_id_t
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  input  logic clear_i,
  input  T     d_i,
  output T     q_o
);

  T slot_d, slot_q;

  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      slot_d = T'('0);
    end else if (!hold_i) begin
      slot_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= T'('0);
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it to the combinational
// instruction memory, and captures the returned word with PC+step into IF/ID.
// Branch redirect beats freeze for both the PC and the IF/ID slot.
//   clk, rst : clock, asynchronous active-high reset
//   fe       : fetch bus (control in, memory port, IF/ID and fetch counter out)
module fetch_stage #(
  parameter int unsigned      WIDTH    = core_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      PC_STEP  = core_pkg::PC_STEP
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fe
);
  import core_pkg::*;

  logic [WIDTH-1:0] pc_d, pc_q;
  logic [WIDTH-1:0] count_d, count_q;
  logic [WIDTH-1:0] pc_next_seq;
  logic             capture;
  if_id_t           if_id_d, if_id_q;

  // Wraps naturally modulo 2^WIDTH.
  assign pc_next_seq = pc_q + WIDTH'(PC_STEP);

  // A capture only happens when neither redirecting nor stalled.
  assign capture = !fe.br_taken && !fe.freeze;

  always_comb begin
    pc_d = pc_next_seq;
    if (fe.br_taken) begin
      pc_d = word_align(fe.br_addr);
    end else if (fe.freeze) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    count_d = count_q;
    if (capture) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_comb begin
    if_id_d       = '0;
    if_id_d.pc    = pc_next_seq;
    if_id_d.inst  = fe.inst_in;
    if_id_d.valid = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Flush on redirect: the instruction currently in IF is on the wrong path.
  if_id_reg #(
    .T(if_id_t)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .hold_i (fe.freeze),
    .clear_i(fe.br_taken),
    .d_i    (if_id_d),
    .q_o    (if_id_q)
  );

  assign fe.inst_adrs   = pc_q;
  assign fe.if_id_pc    = if_id_q.pc;
  assign fe.if_id_inst  = if_id_q.inst;
  assign fe.if_id_valid = if_id_q.valid;
  assign fe.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_stage_if #(.WIDTH(32)) bus  ();
  fetch_stage_if #(.WIDTH(32)) wbus ();

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .fe (bus)
  );

  fetch_stage #(
    .RESET_PC(32'hFFFF_FFFC)
  ) u_wrap (
    .clk(clk),
    .rst(rst),
    .fe (wbus)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a short test program, then an address hash.
  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] w;
    if (a < 32'd24) begin
      case (a[4:2])
        3'd0:    w = 32'h0000_0013;
        3'd1:    w = 32'h8001_060A;
        3'd2:    w = 32'h1234_5678;
        3'd3:    w = 32'hDEAD_BEEF;
        3'd4:    w = 32'h0BAD_F00D;
        default: w = 32'hCAFE_0014;
      endcase
    end else begin
      w = {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    end
    return w;
  endfunction

  assign bus.inst_in  = imem(bus.inst_adrs);
  assign wbus.inst_in = imem(wbus.inst_adrs);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state: architectural PC, IF/ID slot, capture count.
  logic [31:0] m_pc, m_ifpc, m_inst, m_cnt;
  logic        m_vld;

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_inst = NOP_INST; m_vld = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".inst_adrs"},   bus.inst_adrs,   m_pc);
    check_eq({ctx, ".if_id_pc"},    bus.if_id_pc,    m_ifpc);
    check_eq({ctx, ".if_id_inst"},  bus.if_id_inst,  m_inst);
    check_eq({ctx, ".if_id_valid"}, 32'(bus.if_id_valid), 32'(m_vld));
    check_eq({ctx, ".fetch_count"}, bus.fetch_count, m_cnt);
  endtask

  // One clock edge: advance the model from current inputs, then compare.
  task automatic tick(input string ctx);
    logic [31:0] word;
    word = imem(m_pc);
    if (bus.br_taken) begin
      m_pc = {bus.br_addr[31:2], 2'b00};
      m_ifpc = 32'h0; m_inst = NOP_INST; m_vld = 1'b0;
    end else if (!bus.freeze) begin
      m_inst = word;
      m_ifpc = m_pc + 32'd4;
      m_vld  = 1'b1;
      m_cnt  = m_cnt + 32'd1;
      m_pc   = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  // Asynchronous reset pulse asserted mid-cycle; values must drop at once.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    check_eq("rst.inst_adrs",   bus.inst_adrs,   32'h0);
    check_eq("rst.if_id_valid", 32'(bus.if_id_valid), 32'h0);
    check_eq("rst.if_id_inst",  bus.if_id_inst,  32'h0);
    check_eq("rst.if_id_pc",    bus.if_id_pc,    32'h0);
    check_eq("rst.fetch_count", bus.fetch_count, 32'h0);
    @(posedge clk);
    #4 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.freeze = 1'b0; bus.br_taken = 1'b0; bus.br_addr = '0;
    wbus.freeze = 1'b0; wbus.br_taken = 1'b0; wbus.br_addr = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #5 rst = 1'b0;
    check_all("reset");
    check_eq("wrap.first_adrs", wbus.inst_adrs, 32'hFFFF_FFFC);

    // Sequential fetch from 0.
    tick("seq1");
    check_eq("seq1.adrs", bus.inst_adrs, 32'h4);
    check_eq("wrap.adrs", wbus.inst_adrs, 32'h0);
    check_eq("wrap.if_id_pc", wbus.if_id_pc, 32'h0);
    tick("seq2");
    check_eq("seq2.inst", bus.if_id_inst, 32'h8001_060A);
    check_eq("seq2.pc",   bus.if_id_pc,   32'h8);
    check_eq("seq2.cnt",  bus.fetch_count, 32'd2);
    tick("seq3");
    tick("seq4");
    check_eq("pre_freeze.adrs", bus.inst_adrs, 32'h10);

    // Freeze two cycles at 0x10.
    bus.freeze = 1'b1;
    tick("frz1");
    tick("frz2");
    check_eq("frz.adrs", bus.inst_adrs, 32'h10);
    check_eq("frz.cnt",  bus.fetch_count, 32'd4);
    bus.freeze = 1'b0;
    tick("frz_rel");
    check_eq("frz_rel.adrs", bus.inst_adrs, 32'h14);

    // Redirect to 0x0C, then back-to-back branch to 0x17 (aligned 0x14).
    bus.br_taken = 1'b1; bus.br_addr = 32'h0000_000E;
    tick("br_a");
    check_eq("br_a.adrs", bus.inst_adrs, 32'hC);
    bus.br_addr = 32'h0000_0017;
    tick("br_b");
    check_eq("br_b.adrs",  bus.inst_adrs, 32'h14);
    check_eq("br_b.valid", 32'(bus.if_id_valid), 32'h0);
    check_eq("br_b.inst",  bus.if_id_inst, 32'h0);
    bus.br_taken = 1'b0;
    tick("br_c");
    check_eq("br_c.inst", bus.if_id_inst, 32'hCAFE_0014);
    check_eq("br_c.pc",   bus.if_id_pc,   32'h18);

    // Branch and freeze together: branch wins.
    bus.br_taken = 1'b1; bus.freeze = 1'b1; bus.br_addr = 32'h4;
    tick("brfrz");
    check_eq("brfrz.adrs",  bus.inst_adrs, 32'h4);
    check_eq("brfrz.valid", 32'(bus.if_id_valid), 32'h0);
    bus.br_taken = 1'b0; bus.freeze = 1'b0;
    tick("brfrz_after");

    do_reset();
    tick("post_rst");

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 500; i++) begin
      bus.freeze   = ($urandom_range(3) == 0);
      bus.br_taken = ($urandom_range(7) == 0);
      bus.br_addr  = $urandom();
      if ($urandom_range(60) == 0) begin
        bus.freeze = 1'b0; bus.br_taken = 1'b0;
        do_reset();
      end
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
